execute_unit: RTL and testbench
===============================

// Module: execute_unit
// PURPOSE
//   Execute stage of the 8-bit core, directly downstream of allocate. Consumes the
//   registered source operands (src1, src2-or-imm) plus opcode and destination index,
//   computes the ALU result (single-cycle ops or iterative shift-add MUL), and
//   presents {idx,val} to writeback with a valid/ready handshake and Z/C flags.
// PARAMETERS
//   DATA_W     8  operand/result width
//   IDX_W      2  destination register index width (4 registers)
// PORTS
//   iCLK        in   1       clock, all state on rising edge
//   iRST_N      in   1       asynchronous reset, active-low
//   iVALID      in   1       operands/opcode valid this cycle
//   oREADY      out  1       block can accept an op this cycle
//   iOPCODE     in   4       operation select (encoding below)
//   iSRC1       in   DATA_W  source 1 value
//   iSRC2       in   DATA_W  source 2 value (register or immediate, already muxed)
//   iDST_IDX    in   IDX_W   destination register index
//   oWB_VALID   out  1       writeback result valid
//   iWB_READY   in   1       writeback consumes result this cycle
//   oWB_IDX     out  IDX_W   destination index of result
//   oWB_VAL     out  DATA_W  result value
//   oFLAG_Z     out  1       result == 0 (last completed op)
//   oFLAG_C     out  1       carry/borrow/shift-out/overflow (last completed op)
//   oILLEGAL    out  1       one-cycle pulse: illegal opcode accepted and dropped
//   oBUSY       out  1       MUL iteration in progress
// BEHAVIOUR
//   - Reset (iRST_N=0, async): state IDLE; all outputs 0 except oREADY=1.
//   - Opcodes: 0 MOV(=src2) 1 ADD 2 SUB 3 AND 4 OR 5 XOR 6 SHL 7 SHR 8 MUL; 9-15 illegal.
//   - Accept = iVALID & oREADY; operands, opcode, dst latched at that edge.
//   - States: IDLE, MUL, DONE. oREADY = (IDLE) | (DONE & iWB_READY); 0 in MUL.
//   - IDLE/DONE-drain + accept single-cycle op -> DONE, oWB_VALID=1 next cycle (latency 1).
//   - Accept MUL -> MUL; counter 0..DATA_W-1, one shift-add step per cycle;
//     after DATA_W cycles -> DONE (oWB_VALID at accept edge + DATA_W + 1). oBUSY=1 in MUL.
//   - DONE: outputs held stable while iWB_READY=0. iWB_READY=1: result retired; same edge
//     may accept next op (back-to-back, no bubble); else -> IDLE, oWB_VALID=0.
//   - Illegal opcode: accepted, oILLEGAL=1 for one cycle, no oWB_VALID, flags unchanged,
//     next state IDLE.
//   - Arithmetic modulo 2^DATA_W. C: ADD carry-out; SUB borrow (src1<src2);
//     SHL last bit shifted out of MSB; SHR last bit shifted out of LSB; shift amount
//     src2[2:0], amount 0 -> C=0; MUL C = |product[15:8], val = product[7:0];
//     MOV/AND/OR/XOR C=0.
//   - Flags update only on the edge entering DONE; held otherwise.
//   - iVALID while not ready: ignored, upstream holds. iVALID in MUL never accepted.
//   - Reset mid-MUL or mid-DONE: result discarded, no writeback pulse.
// TESTING
//   ADD 200+100 dst=2, iWB_READY=1 -> next cycle oWB_VALID=1 idx=2 val=44 C=1 Z=0.
//   SUB 5-5 then SUB 3-4 back-to-back -> val=0 Z=1 C=0, then val=255 C=1, no bubble.
//   MUL 15*17 -> oBUSY 8 cycles, oREADY=0, oWB_VALID at accept+9, val=255 C=0;
//     MUL 16*16 -> val=0 Z=1 C=1.
//   ADD 1+1 with iWB_READY=0 for 3 cycles -> oWB_VALID/val=2 held, oREADY=0, new iVALID
//     ignored until iWB_READY=1.
//   Opcode 12 -> oILLEGAL one-cycle pulse, no oWB_VALID, Z/C unchanged; SHL 0x81 by 1 -> val=2 C=1.
//   iRST_N low at MUL cycle 4 -> outputs 0 immediately, oREADY=1, no writeback after release.

Source files
------------

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier,
// presenting {idx,val} and Z/C flags to writeback over a valid/ready handshake.
module execute_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    output logic              ready,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [IDX_W-1:0]  dst_idx,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [IDX_W-1:0]  wb_idx,
    output logic [DATA_W-1:0] wb_val,
    output logic              flag_z,
    output logic              flag_c,
    output logic              illegal,
    output logic              busy
);

    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned SHAMT_W = 3;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [PROD_W-1:0]   mul_acc;
    logic [PROD_W-1:0]   mul_mcand;
    logic [DATA_W-1:0]   mul_mplier;
    logic [CNT_W-1:0]    mul_cnt;
    logic [PROD_W-1:0]   mul_step;
    logic                accept;
    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W:0]     ext;
    logic [DATA_W-1:0]   alu_val;
    logic                alu_c;

    // A finished result can be retired and replaced on the same edge.
    assign ready    = (state == S_IDLE) | ((state == S_DONE) & wb_ready);
    assign accept   = valid & ready;
    assign shamt    = src2[SHAMT_W-1:0];
    assign mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : PROD_W'(0));

    // Single-cycle ALU result and carry, evaluated on the incoming operands.
    always_comb begin
        ext     = '0;
        alu_val = '0;
        alu_c   = 1'b0;
        case (opcode)
            OP_MOV: alu_val = src2;
            OP_ADD: begin
                ext     = {1'b0, src1} + {1'b0, src2};
                alu_val = ext[DATA_W-1:0];
                alu_c   = ext[DATA_W];
            end
            OP_SUB: begin
                ext     = {1'b0, src1} - {1'b0, src2};
                alu_val = ext[DATA_W-1:0];
                alu_c   = ext[DATA_W];
            end
            OP_AND: alu_val = src1 & src2;
            OP_OR:  alu_val = src1 | src2;
            OP_XOR: alu_val = src1 ^ src2;
            OP_SHL: begin
                // Bit DATA_W catches the last bit pushed out of the MSB.
                ext     = {1'b0, src1} << shamt;
                alu_val = ext[DATA_W-1:0];
                alu_c   = ext[DATA_W];
            end
            OP_SHR: begin
                // Bit 0 catches the last bit pushed out of the LSB.
                ext     = {src1, 1'b0} >> shamt;
                alu_val = ext[DATA_W:1];
                alu_c   = ext[0];
            end
            default: ;
        endcase
    end

    // Control FSM, multiplier datapath and registered writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wb_valid   <= 1'b0;
            wb_idx     <= '0;
            wb_val     <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            illegal    <= 1'b0;
            busy       <= 1'b0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (opcode == OP_MUL) begin
                            state      <= S_MUL;
                            busy       <= 1'b1;
                            wb_valid   <= 1'b0;
                            wb_idx     <= dst_idx;
                            mul_acc    <= '0;
                            mul_mcand  <= PROD_W'(src1);
                            mul_mplier <= src2;
                            mul_cnt    <= '0;
                        end else if (opcode < OP_MUL) begin
                            state    <= S_DONE;
                            wb_valid <= 1'b1;
                            wb_idx   <= dst_idx;
                            wb_val   <= alu_val;
                            flag_z   <= (alu_val == '0);
                            flag_c   <= alu_c;
                        end else begin
                            state    <= S_IDLE;
                            wb_valid <= 1'b0;
                            illegal  <= 1'b1;
                        end
                    end else if ((state == S_DONE) && wb_ready) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    mul_acc    <= mul_step;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + CNT_W'(1);
                    if (mul_cnt == CNT_W'(DATA_W - 1)) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_val   <= mul_step[DATA_W-1:0];
                        flag_z   <= (mul_step[DATA_W-1:0] == '0);
                        flag_c   <= |mul_step[PROD_W-1:DATA_W];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed scenarios plus randomized ops against an
// arithmetic reference model.
module tb_execute_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       ready;
    logic [3:0] opcode = 4'd0;
    logic [7:0] src1 = 8'd0;
    logic [7:0] src2 = 8'd0;
    logic [1:0] dst_idx = 2'd0;
    logic       wb_valid;
    logic       wb_ready = 1'b0;
    logic [1:0] wb_idx;
    logic [7:0] wb_val;
    logic       flag_z;
    logic       flag_c;
    logic       illegal;
    logic       busy;

    int errors = 0;
    int checks = 0;

    execute_unit #(.DATA_W(8), .IDX_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .ready    (ready),
        .opcode   (opcode),
        .src1     (src1),
        .src2     (src2),
        .dst_idx  (dst_idx),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_idx   (wb_idx),
        .wb_val   (wb_val),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .illegal  (illegal),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result value and carry computed with plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b,
                                  output int val, output int c);
        int amt;
        int s;
        amt = b % 8;
        val = 0;
        c   = 0;
        case (op)
            0: val = b;
            1: begin s = a + b; val = s % 256; c = (s > 255) ? 1 : 0; end
            2: begin val = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            3: val = a & b;
            4: val = a | b;
            5: val = a ^ b;
            6: begin s = a * (1 << amt); val = s % 256; c = (amt == 0) ? 0 : (s / 256) % 2; end
            7: begin val = a / (1 << amt); c = (amt == 0) ? 0 : (a / (1 << (amt - 1))) % 2; end
            8: begin s = a * b; val = s % 256; c = (s > 255) ? 1 : 0; end
            default: ;
        endcase
    endfunction

    // Present an op and hold it until the block accepts; returns one cycle after the accept edge.
    task automatic issue(input int op, input int a, input int b, input int d);
        bit done;
        int n;
        opcode  = 4'(op);
        src1    = 8'(a);
        src2    = 8'(b);
        dst_idx = 2'(d);
        valid   = 1'b1;
        done    = 1'b0;
        n       = 0;
        while (!done && n < 40) begin
            #1;
            if (ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        valid = 1'b0;
        if (!done) check("accept_timeout", 32'(0), 32'(1));
    endtask

    // Count cycles after the accept edge until a result shows up.
    task automatic wait_wb(output int lat);
        lat = 1;
        while (!wb_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    int mz;
    int mc;

    initial begin
        int ev;
        int ec;
        int lat;
        int op;
        int a;
        int b;
        int d;
        int stall;
        bit seen;

        // Reset values
        #2;
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_wb_valid", 32'(wb_valid), 32'(0));
        check("rst_wb_val", 32'(wb_val), 32'(0));
        check("rst_wb_idx", 32'(wb_idx), 32'(0));
        check("rst_flags", 32'({flag_z, flag_c}), 32'(0));
        check("rst_illegal_busy", 32'({illegal, busy}), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ADD with carry out
        wb_ready = 1'b1;
        issue(1, 200, 100, 2);
        check("add_valid", 32'(wb_valid), 32'(1));
        check("add_idx", 32'(wb_idx), 32'(2));
        check("add_val", 32'(wb_val), 32'(44));
        check("add_c", 32'(flag_c), 32'(1));
        check("add_z", 32'(flag_z), 32'(0));
        tick();
        check("add_retired", 32'(wb_valid), 32'(0));

        // Back-to-back SUBs without a bubble
        issue(2, 5, 5, 1);
        check("sub0_val", 32'(wb_val), 32'(0));
        check("sub0_zc", 32'({flag_z, flag_c}), 32'(2));
        opcode = 4'd2; src1 = 8'd3; src2 = 8'd4; dst_idx = 2'd3; valid = 1'b1;
        #1;
        check("sub_b2b_ready", 32'(ready), 32'(1));
        tick();
        valid = 1'b0;
        check("sub1_valid", 32'(wb_valid), 32'(1));
        check("sub1_val", 32'(wb_val), 32'(255));
        check("sub1_zc", 32'({flag_z, flag_c}), 32'(1));
        check("sub1_idx", 32'(wb_idx), 32'(3));
        tick();
        check("sub1_retired", 32'(wb_valid), 32'(0));

        // MUL 15*17 with a stalled consumer and an upstream op waiting
        wb_ready = 1'b0;
        issue(8, 15, 17, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!busy || ready || wb_valid) seen = 1'b1;
            opcode = 4'd1; src1 = 8'd9; src2 = 8'd9; valid = 1'b1;
            tick();
        end
        check("mul_busy_window", 32'(seen), 32'(0));
        check("mul_valid_at_9", 32'(wb_valid), 32'(1));
        check("mul_val", 32'(wb_val), 32'(255));
        check("mul_zc", 32'({flag_z, flag_c}), 32'(0));
        check("mul_busy_clear", 32'(busy), 32'(0));
        check("mul_done_ready", 32'(ready), 32'(0));
        valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        check("mul_retired", 32'(wb_valid), 32'(0));

        issue(8, 16, 16, 1);
        wait_wb(lat);
        check("mul2_lat", 32'(lat), 32'(9));
        check("mul2_val", 32'(wb_val), 32'(0));
        check("mul2_zc", 32'({flag_z, flag_c}), 32'(3));
        tick();

        // Illegal opcode leaves flags alone
        issue(12, 1, 2, 3);
        check("ill_pulse", 32'(illegal), 32'(1));
        check("ill_no_wb", 32'(wb_valid), 32'(0));
        check("ill_flags", 32'({flag_z, flag_c}), 32'(3));
        tick();
        check("ill_pulse_end", 32'(illegal), 32'(0));
        check("ill_ready", 32'(ready), 32'(1));

        issue(6, 8'h81, 1, 2);
        check("shl_val", 32'(wb_val), 32'(2));
        check("shl_c", 32'(flag_c), 32'(1));
        tick();

        // Consumer stall holds the result and blocks new ops
        wb_ready = 1'b0;
        issue(1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            opcode = 4'd5; src1 = 8'd3; src2 = 8'd5; valid = 1'b1;
            #1;
            check("stall_ready", 32'(ready), 32'(0));
            check("stall_hold", 32'({wb_valid, wb_val}), 32'({1'b1, 8'd2}));
            tick();
        end
        check("stall_val_after", 32'(wb_val), 32'(2));
        valid = 1'b0;
        wb_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(ready), 32'(1));
        tick();
        check("stall_retired", 32'(wb_valid), 32'(0));

        // Reset in the middle of a MUL
        issue(8, 15, 17, 2);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_outs", 32'({wb_valid, busy, illegal, flag_z, flag_c}), 32'(0));
        check("rstmid_ready", 32'(ready), 32'(1));
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wb_valid) seen = 1'b1;
        end
        check("rstmid_no_wb", 32'(seen), 32'(0));
        mz = 0;
        mc = 0;

        // Randomized ops against the reference model
        for (int t = 0; t < 250; t++) begin
            op = $urandom_range(0, 9);
            if (op == 9) op = $urandom_range(9, 15);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            d = $urandom_range(0, 3);
            stall = $urandom_range(0, 3);
            wb_ready = (stall == 0);
            issue(op, a, b, d);
            if (op > 8) begin
                check("rnd_ill", 32'({illegal, wb_valid}), 32'(2));
                check("rnd_ill_flags", 32'({flag_z, flag_c}), 32'({mz[0], mc[0]}));
                tick();
            end else begin
                model(op, a, b, ev, ec);
                mz = (ev == 0) ? 1 : 0;
                mc = ec;
                wait_wb(lat);
                check("rnd_lat", 32'(lat), 32'((op == 8) ? 9 : 1));
                check("rnd_idx", 32'(wb_idx), 32'(d));
                check("rnd_val", 32'(wb_val), 32'(ev));
                check("rnd_flags", 32'({flag_z, flag_c}), 32'({mz[0], mc[0]}));
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check("rnd_hold", 32'({wb_valid, wb_val}), 32'({1'b1, 8'(ev)}));
                end
                wb_ready = 1'b1;
                tick();
                check("rnd_retired", 32'(wb_valid), 32'(0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
